// File: rtl/tx_word_pacer.sv
// Paces 10-bit encoded words into an 8-valid/2-idle slot cadence, filling empty slots with K28.5 commas.
// Optional TX_PACER_STATS_EN adds a saturating comma counter and a sticky underrun flag.
module tx_word_pacer #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [9:0]  IDLE_K_NEG = 10'b0011111010,
  parameter logic [9:0]  IDLE_K_POS = 10'b1100000101
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [9:0]  in_data,
  output logic        in_ready,
  output logic        valid,
  output logic [9:0]  data_out,
`ifdef TX_PACER_STATS_EN
  output logic [15:0] idle_count,
  output logic        underrun_flag,
`endif
  output logic        is_idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    slot_q, slot_d;
  logic          run_q;
  logic          pol_q, pol_d;
  logic          valid_q, valid_d;
  logic [9:0]    data_q, data_d;
  logic          idle_q, idle_d;

  logic full, empty, push, slot_act, pop, ins_idle;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // run_q holds ready low through reset and releases it one clock after rst_n rises.
  assign in_ready = run_q && !full;
  assign push     = in_valid && in_ready;
  assign slot_act = (slot_q < 4'd8);
  assign pop      = slot_act && !empty;
  assign ins_idle = slot_act && empty;

  always_comb begin
    slot_d   = (slot_q == 4'd9) ? 4'd0 : slot_q + 4'd1;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    valid_d  = slot_act;
    data_d   = data_q;
    idle_d   = idle_q;
    pol_d    = pol_q;
    if (pop) begin
      data_d = mem_q[rd_ptr_q[AW-1:0]];
      idle_d = 1'b0;
    end else if (ins_idle) begin
      data_d = pol_q ? IDLE_K_POS : IDLE_K_NEG;
      idle_d = 1'b1;
      pol_d  = ~pol_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q   <= 4'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      run_q    <= 1'b0;
      pol_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= 10'd0;
      idle_q   <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      run_q    <= 1'b1;
      pol_q    <= pol_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      idle_q   <= idle_d;
    end
  end

  assign valid    = valid_q;
  assign data_out = data_q;
  assign is_idle  = idle_q;

`ifdef TX_PACER_STATS_EN
  logic [15:0] idle_cnt_q;
  logic        underrun_q;
  logic        seen_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt_q  <= 16'd0;
      underrun_q  <= 1'b0;
      seen_data_q <= 1'b0;
    end else begin
      if (ins_idle) idle_cnt_q <= sat_inc16(idle_cnt_q);
      if (ins_idle && seen_data_q) underrun_q <= 1'b1;
      if (pop) seen_data_q <= 1'b1;
    end
  end

  assign idle_count    = idle_cnt_q;
  assign underrun_flag = underrun_q;
`endif

endmodule
